// File: rtl/spi_master_interface_if.sv
// Handshake and SPI pin bundle for spi_master_interface.
// The master modport is the controller side; slave is the view of whatever drives start/miso.
interface spi_master_interface_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                  start;
    logic [DATA_WIDTH-1:0] data_to_send;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] data_received;
    logic                  cs;
    logic                  sck;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start, data_to_send, miso,
        output busy, done, data_received, cs, sck, mosi
    );

    modport slave (
        output start, data_to_send, miso,
        input  busy, done, data_received, cs, sck, mosi
    );
endinterface

// File: rtl/spi_master_interface.sv
// SPI Mode 0 master: one DATA_WIDTH-bit word per transaction, sck from a clock-enable divider.
// Optional macro SPI_MASTER_LSB_FIRST_EN reverses the shift direction (LSB first).
module spi_master_interface #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    spi_master_interface_if.master bus
);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam int unsigned FIRST = 0;
`else
    localparam int unsigned FIRST = DATA_WIDTH - 1;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] drx_q, drx_d;
    logic                  cs_q, cs_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  phase_end;
    logic [DATA_WIDTH-1:0] tx_rot;
    logic [DATA_WIDTH-1:0] rx_shift;

    // Transmit word rotates so the next bit to send always sits at FIRST.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_rot   = {tx_q[0], tx_q[DATA_WIDTH-1:1]};
    assign rx_shift = {bus.miso, rx_q[DATA_WIDTH-1:1]};
`else
    assign tx_rot   = {tx_q[DATA_WIDTH-2:0], tx_q[DATA_WIDTH-1]};
    assign rx_shift = {rx_q[DATA_WIDTH-2:0], bus.miso};
`endif

    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state and next-output logic; every output is registered from its _d value.
    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || phase_end) ? '0 : div_q + DIV_W'(1);
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        drx_d   = drx_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    tx_d    = bus.data_to_send;
                    rx_d    = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = bus.data_to_send[FIRST];
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = HIGH;
                    sck_d   = 1'b1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_d = LOW;
                    sck_d   = 1'b0;
                    rx_d    = rx_shift;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q != BIT_W'(DATA_WIDTH - 1)) begin
                        tx_d   = tx_rot;
                        mosi_d = tx_rot[FIRST];
                    end
                end
            end
            LOW: begin
                if (phase_end) begin
                    if (bit_q == BIT_W'(DATA_WIDTH)) begin
                        state_d = GAP;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                        drx_d   = rx_q;
                    end else begin
                        state_d = HIGH;
                        sck_d   = 1'b1;
                    end
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            drx_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            drx_q   <= drx_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.cs            = cs_q;
    assign bus.sck           = sck_q;
    assign bus.mosi          = mosi_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.data_received = drx_q;
endmodule
